player_input_ctrl: RTL and testbench
====================================

PLAYER_INPUT_CTRL -- requirements
Module: player_input_ctrl

Interface
REQ-001 Parameter COIN_CYCLES, default 20'd500000: minimum coin output high time, in clk cycles.
REQ-002 clk  in  1  system clock; single clock domain; all logic on rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
REQ-004 ps2_key  in  11  HPS keyboard event: [10] toggle strobe, [9] pressed, [7:0] scan code.
REQ-005 joystick_0  in  32  player 1 HPS joystick; bits [10:0] used.
REQ-006 joystick_1  in  32  player 2 HPS joystick; bits [10:0] used.
REQ-007 p1  out  10  player 1 controls, registered; layout below.
REQ-008 p2  out  10  player 2 controls, registered; same layout.
REQ-009 service  out  2  [0] service 1, [1] service 2, registered.

Function
REQ-010 Control layout SHALL be [0]right [1]left [2]down [3]up [4]b1 [5]b2 [6]b3 [7]start [8]coin [9]pause, matching joystick bits [9:0].
REQ-011 Key event SHALL be detected when ps2_key[10] differs from its value registered on the previous cycle; no event otherwise.
REQ-012 On event, key bit for code SHALL be set to ps2_key[9]: 75 up, 72 down, 6B left, 74 right, 14 b1, 11 b2, 29 b3, 16 start, 2E coin, 4D pause (P1); 2D up, 2B down, 23 left, 34 right, 1C b1, 1B b2, 15 b3, 1E start, 36 coin (P2); 46 service1, 45 service2.
REQ-013 Unlisted codes SHALL leave all key registers unchanged.
REQ-014 Each raw control SHALL be key bit OR joystick bit; P2 pause is joystick_1[9] only; service1 = key46 | joystick_0[10], service2 = key45 | joystick_1[10].
REQ-015 Joystick-to-output latency SHALL be exactly 1 cycle; ps2_key toggle-to-output latency exactly 2 cycles.
REQ-016 Per player, coin stretcher SHALL be a 20-bit down-counter: raw coin rising edge loads COIN_CYCLES-1; counter decrements to 0 and holds.
REQ-017 Coin output SHALL be high while raw coin high or counter nonzero; minimum high width COIN_CYCLES cycles.
REQ-018 Rising edge of raw coin while counter nonzero SHALL reload counter (retrigger), no gap in output.
REQ-019 COIN_CYCLES of 0 or 1 SHALL give coin output equal to raw coin delayed 1 cycle.
REQ-020 Simultaneous key release and joystick press of same control SHALL yield output high (OR rule).
REQ-021 Keyboard press and release in consecutive events SHALL each be applied; no event is dropped at one event per cycle.

Reset
REQ-022 rst_n low SHALL clear immediately all key registers, coin counters, coin edge registers, p1, p2, service to 0.
REQ-023 Toggle history register SHALL load ps2_key[10] on the first clock after rst_n deasserts, with no decode in that cycle.
REQ-024 Reset asserted mid coin stretch SHALL abort the stretch; output 0 until a new rising edge after reset.

Configuration
REQ-025 Macro PLAYER_INPUT_CTRL_KEYBOARD_EN defined: keyboard decode per REQ-011..013 included.
REQ-026 Macro undefined: no key registers synthesised; ps2_key ignored; outputs derive from joysticks only; latency per REQ-015 unchanged for joysticks.

Verification
REQ-027 joystick_0=32'h0000_0011 -> p1=10'h011 one cycle later; clear -> p1=0 one cycle later.
REQ-028 ps2_key toggles with pressed=1 code 8'h75 -> p1[3]=1 two cycles later; release event same code -> p1[3]=0; code 8'h99 -> no output change.
REQ-029 COIN_CYCLES=10, joystick_1[8] high 1 cycle -> p2[8] high exactly 10 cycles; second pulse at cycle 5 -> high until 10 cycles after second edge.
REQ-030 ps2_key[10]=1 held through reset release -> no key register changes; next toggle decoded normally.
REQ-031 rst_n low at cycle 4 of a 10-cycle coin stretch -> p1[8]=0 immediately, stays 0 after release with coin input low.
REQ-032 Build without PLAYER_INPUT_CTRL_KEYBOARD_EN, key 8'h16 press event -> p1[7] stays 0; joystick_0[7] -> p1[7]=1.

Source files
------------

// File: rtl/player_input_ctrl.sv
// Merges HPS keyboard and joystick inputs into registered player/service controls with coin stretching.
// Keyboard decode is built only when PLAYER_INPUT_CTRL_KEYBOARD_EN is defined.
module player_input_ctrl #(
  parameter logic [19:0] COIN_CYCLES = 20'd500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] ps2_key,
  input  logic [31:0] joystick_0,
  input  logic [31:0] joystick_1,
  output logic [9:0]  p1,
  output logic [9:0]  p2,
  output logic [1:0]  service
);

  // Loading COIN_CYCLES-1 gives COIN_CYCLES high cycles including the raw-coin cycle.
  localparam logic [19:0] COIN_LOAD = (COIN_CYCLES == 20'd0) ? 20'd0 : (COIN_CYCLES - 20'd1);

  logic [9:0] kb_p1;
  logic [9:0] kb_p2;
  logic [1:0] kb_srv;

`ifdef PLAYER_INPUT_CTRL_KEYBOARD_EN
  logic [9:0] key1_q, key1_d;
  logic [8:0] key2_q, key2_d;
  logic [1:0] ksrv_q, ksrv_d;
  logic       tgl_q, tgl_d;
  logic       armed_q, armed_d;
  logic       key_event;
  logic       unused_kb;

  // armed_q holds off decode for the first clock after reset while tgl_q captures the strobe.
  always_comb begin
    key1_d    = key1_q;
    key2_d    = key2_q;
    ksrv_d    = ksrv_q;
    tgl_d     = ps2_key[10];
    armed_d   = 1'b1;
    key_event = armed_q && (ps2_key[10] != tgl_q);
    if (key_event) begin
      case (ps2_key[7:0])
        8'h74: key1_d[0] = ps2_key[9];
        8'h6B: key1_d[1] = ps2_key[9];
        8'h72: key1_d[2] = ps2_key[9];
        8'h75: key1_d[3] = ps2_key[9];
        8'h14: key1_d[4] = ps2_key[9];
        8'h11: key1_d[5] = ps2_key[9];
        8'h29: key1_d[6] = ps2_key[9];
        8'h16: key1_d[7] = ps2_key[9];
        8'h2E: key1_d[8] = ps2_key[9];
        8'h4D: key1_d[9] = ps2_key[9];
        8'h34: key2_d[0] = ps2_key[9];
        8'h23: key2_d[1] = ps2_key[9];
        8'h2B: key2_d[2] = ps2_key[9];
        8'h2D: key2_d[3] = ps2_key[9];
        8'h1C: key2_d[4] = ps2_key[9];
        8'h1B: key2_d[5] = ps2_key[9];
        8'h15: key2_d[6] = ps2_key[9];
        8'h1E: key2_d[7] = ps2_key[9];
        8'h36: key2_d[8] = ps2_key[9];
        8'h46: ksrv_d[0] = ps2_key[9];
        8'h45: ksrv_d[1] = ps2_key[9];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key1_q  <= '0;
      key2_q  <= '0;
      ksrv_q  <= '0;
      tgl_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      key1_q  <= key1_d;
      key2_q  <= key2_d;
      ksrv_q  <= ksrv_d;
      tgl_q   <= tgl_d;
      armed_q <= armed_d;
    end
  end

  assign kb_p1     = key1_q;
  assign kb_p2     = {1'b0, key2_q};
  assign kb_srv    = ksrv_q;
  assign unused_kb = ps2_key[8];
`else
  logic unused_kb;
  assign kb_p1     = '0;
  assign kb_p2     = '0;
  assign kb_srv    = '0;
  assign unused_kb = &{1'b0, ps2_key};
`endif

  logic [9:0]       raw1, raw2;
  logic [1:0]       raw_coin, coin_out;
  logic [1:0]       coin_prev_q, coin_prev_d;
  logic [1:0][19:0] cnt_q, cnt_d;
  logic [9:0]       p1_q, p1_d, p2_q, p2_d;
  logic [1:0]       service_q, service_d;
  logic             unused_joy;

  assign raw1       = kb_p1 | joystick_0[9:0];
  assign raw2       = kb_p2 | joystick_1[9:0];
  assign raw_coin   = {raw2[8], raw1[8]};
  assign unused_joy = &{1'b0, joystick_0[31:11], joystick_1[31:11]};

  // A rising raw coin reloads even mid-stretch, so a retrigger never opens a gap.
  always_comb begin
    cnt_d       = cnt_q;
    coin_out    = '0;
    coin_prev_d = raw_coin;
    for (int i = 0; i < 2; i++) begin
      if (raw_coin[i] && !coin_prev_q[i]) begin
        cnt_d[i] = COIN_LOAD;
      end else if (cnt_q[i] != 20'd0) begin
        cnt_d[i] = cnt_q[i] - 20'd1;
      end
      coin_out[i] = raw_coin[i] | (cnt_q[i] != 20'd0);
    end
    p1_d      = raw1;
    p1_d[8]   = coin_out[0];
    p2_d      = raw2;
    p2_d[8]   = coin_out[1];
    service_d = {kb_srv[1] | joystick_1[10], kb_srv[0] | joystick_0[10]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      coin_prev_q <= '0;
      p1_q        <= '0;
      p2_q        <= '0;
      service_q   <= '0;
    end else begin
      cnt_q       <= cnt_d;
      coin_prev_q <= coin_prev_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      service_q   <= service_d;
    end
  end

  assign p1      = p1_q;
  assign p2      = p2_q;
  assign service = service_q;

endmodule

// File: tb/tb_player_input_ctrl.sv
// Bench for player_input_ctrl: table-driven joystick/keyboard vectors plus coin-stretch and reset sequences.
// Keyboard expectations follow PLAYER_INPUT_CTRL_KEYBOARD_EN; a second instance runs with COIN_CYCLES=1.
module tb_player_input_ctrl;

`ifdef PLAYER_INPUT_CTRL_KEYBOARD_EN
  localparam bit KB = 1'b1;
`else
  localparam bit KB = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [10:0] ps2_key;
  logic [31:0] joystick_0;
  logic [31:0] joystick_1;
  logic [9:0]  p1, p2, p1_b, p2_b;
  logic [1:0]  service, service_b;

  int checks   = 0;
  int failures = 0;
  logic [21:0] exp_q[$];

  typedef struct {
    logic [31:0] j0;
    logic [31:0] j1;
    logic [21:0] exp;
  } joy_vec_t;

  typedef struct {
    logic [7:0]  code;
    logic [21:0] exp;
  } key_vec_t;

  joy_vec_t jtab[10];
  key_vec_t ktab[14];

  player_input_ctrl #(.COIN_CYCLES(20'd10)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_key(ps2_key),
    .joystick_0(joystick_0), .joystick_1(joystick_1),
    .p1(p1), .p2(p2), .service(service)
  );

  player_input_ctrl #(.COIN_CYCLES(20'd1)) dut_c1 (
    .clk(clk), .rst_n(rst_n), .ps2_key(ps2_key),
    .joystick_0(joystick_0), .joystick_1(joystick_1),
    .p1(p1_b), .p2(p2_b), .service(service_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [21:0] pk(input logic [9:0] a, input logic [9:0] b, input logic [1:0] s);
    return {a, b, s};
  endfunction

  function automatic logic [21:0] kbx(input logic [21:0] e);
    return KB ? e : 22'd0;
  endfunction

  task automatic push(input logic [21:0] e);
    exp_q.push_back(e);
  endtask

  task automatic compare(input string name);
    logic [21:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: no expected value queued", name);
    end else begin
      e = exp_q.pop_front();
      if ({p1, p2, service} !== e) begin
        failures++;
        $display("FAIL %s: got p1=%h p2=%h service=%b, want p1=%h p2=%h service=%b",
                 name, p1, p2, service, e[21:12], e[11:2], e[1:0]);
      end
    end
  endtask

  task automatic expect_next(input string name);
    @(negedge clk);
    compare(name);
  endtask

  task automatic send_key(input logic [7:0] code, input logic pressed);
    ps2_key = {~ps2_key[10], pressed, 1'b0, code};
  endtask

  initial begin
    logic raw;
    jtab[0] = '{32'h0000_0011, 32'h0, pk(10'h011, 10'h0, 2'b00)};
    jtab[1] = '{32'h0,         32'h0, pk(10'h000, 10'h0, 2'b00)};
    jtab[2] = '{32'h0000_00FF, 32'h0, pk(10'h0FF, 10'h0, 2'b00)};
    jtab[3] = '{32'h0000_0080, 32'h0, pk(10'h080, 10'h0, 2'b00)};
    jtab[4] = '{32'h0, 32'h0000_02F7, pk(10'h000, 10'h2F7, 2'b00)};
    jtab[5] = '{32'h0000_0400, 32'h0, pk(10'h000, 10'h0, 2'b01)};
    jtab[6] = '{32'h0, 32'h0000_0400, pk(10'h000, 10'h0, 2'b10)};
    jtab[7] = '{32'hFFFF_F800, 32'h0, pk(10'h000, 10'h0, 2'b00)};
    jtab[8] = '{32'h0000_0200, 32'h0000_0200, pk(10'h200, 10'h200, 2'b00)};
    jtab[9] = '{32'h0,         32'h0, pk(10'h000, 10'h0, 2'b00)};

    ktab[0]  = '{8'h75, pk(10'h008, 10'h0, 2'b00)};
    ktab[1]  = '{8'h6B, pk(10'h002, 10'h0, 2'b00)};
    ktab[2]  = '{8'h74, pk(10'h001, 10'h0, 2'b00)};
    ktab[3]  = '{8'h29, pk(10'h040, 10'h0, 2'b00)};
    ktab[4]  = '{8'h4D, pk(10'h200, 10'h0, 2'b00)};
    ktab[5]  = '{8'h16, pk(10'h080, 10'h0, 2'b00)};
    ktab[6]  = '{8'h2D, pk(10'h000, 10'h008, 2'b00)};
    ktab[7]  = '{8'h34, pk(10'h000, 10'h001, 2'b00)};
    ktab[8]  = '{8'h1C, pk(10'h000, 10'h010, 2'b00)};
    ktab[9]  = '{8'h1E, pk(10'h000, 10'h080, 2'b00)};
    ktab[10] = '{8'h15, pk(10'h000, 10'h040, 2'b00)};
    ktab[11] = '{8'h46, pk(10'h000, 10'h000, 2'b01)};
    ktab[12] = '{8'h45, pk(10'h000, 10'h000, 2'b10)};
    ktab[13] = '{8'h99, pk(10'h000, 10'h000, 2'b00)};

    // Reset with the strobe held high and a press of 8'h75 presented.
    rst_n      = 1'b1;
    joystick_0 = 32'h0;
    joystick_1 = 32'h0;
    ps2_key    = {1'b1, 1'b1, 1'b0, 8'h75};
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    push(22'd0);
    compare("reset_state");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(22'd0);
      expect_next("strobe_held_thru_reset");
    end
    send_key(8'h75, 1'b1);
    push(22'd0);
    expect_next("first_toggle_lat1");
    push(kbx(pk(10'h008, 10'h0, 2'b00)));
    expect_next("first_toggle_lat2");
    send_key(8'h75, 1'b0);
    push(kbx(pk(10'h008, 10'h0, 2'b00)));
    expect_next("first_release_lat1");
    push(22'd0);
    expect_next("first_release_lat2");

    // Keyboard decode table: press then release, both at two-cycle latency.
    for (int i = 0; i < 14; i++) begin
      send_key(ktab[i].code, 1'b1);
      push(22'd0);
      expect_next($sformatf("key_%h_press_lat1", ktab[i].code));
      push(kbx(ktab[i].exp));
      expect_next($sformatf("key_%h_press_lat2", ktab[i].code));
      send_key(ktab[i].code, 1'b0);
      push(kbx(ktab[i].exp));
      expect_next($sformatf("key_%h_release_lat1", ktab[i].code));
      push(22'd0);
      expect_next($sformatf("key_%h_release_lat2", ktab[i].code));
    end

    // Press and release on consecutive cycles.
    send_key(8'h75, 1'b1);
    push(22'd0);
    expect_next("back_to_back_a");
    send_key(8'h75, 1'b0);
    push(kbx(pk(10'h008, 10'h0, 2'b00)));
    expect_next("back_to_back_b");
    push(22'd0);
    expect_next("back_to_back_c");
    push(22'd0);
    expect_next("back_to_back_d");

    // Joystick table, one-cycle latency.
    for (int i = 0; i < 10; i++) begin
      joystick_0 = jtab[i].j0;
      joystick_1 = jtab[i].j1;
      push(jtab[i].exp);
      expect_next($sformatf("joy_vec_%0d", i));
    end

    // Key release coinciding with a joystick press of the same control.
    send_key(8'h75, 1'b1);
    push(22'd0);
    expect_next("or_rule_press1");
    push(kbx(pk(10'h008, 10'h0, 2'b00)));
    expect_next("or_rule_press2");
    send_key(8'h75, 1'b0);
    joystick_0 = 32'h0000_0008;
    push(pk(10'h008, 10'h0, 2'b00));
    expect_next("or_rule_overlap1");
    push(pk(10'h008, 10'h0, 2'b00));
    expect_next("or_rule_overlap2");
    joystick_0 = 32'h0;
    push(22'd0);
    expect_next("or_rule_clear");

    // Single-cycle P2 coin: exactly 10 cycles high.
    for (int k = 0; k < 13; k++) begin
      joystick_1 = (k == 0) ? 32'h0000_0100 : 32'h0;
      push(pk(10'h0, (k < 10) ? 10'h100 : 10'h0, 2'b00));
      expect_next($sformatf("coin_p2_single_k%0d", k));
    end

    // Retrigger at cycle 5: high until 10 cycles after the second edge.
    for (int k = 0; k < 18; k++) begin
      joystick_1 = (k == 0 || k == 5) ? 32'h0000_0100 : 32'h0;
      push(pk(10'h0, (k <= 14) ? 10'h100 : 10'h0, 2'b00));
      expect_next($sformatf("coin_p2_retrig_k%0d", k));
    end

    // P1 coin pattern; the COIN_CYCLES=1 instance must just delay the raw coin.
    for (int k = 0; k < 15; k++) begin
      raw = (k == 0 || k == 1 || k == 3);
      joystick_0 = raw ? 32'h0000_0100 : 32'h0;
      push(pk((k <= 12) ? 10'h100 : 10'h0, 10'h0, 2'b00));
      expect_next($sformatf("coin_p1_pattern_k%0d", k));
      checks++;
      if (p1_b !== (raw ? 10'h100 : 10'h000)) begin
        failures++;
        $display("FAIL coin_cycles1_k%0d: got p1=%h, want p1=%h", k, p1_b, raw ? 10'h100 : 10'h000);
      end
    end

    // Reset in the middle of a stretch aborts it.
    for (int k = 0; k < 4; k++) begin
      joystick_0 = (k == 0) ? 32'h0000_0100 : 32'h0;
      push(pk(10'h100, 10'h0, 2'b00));
      expect_next($sformatf("abort_pre_k%0d", k));
    end
    rst_n = 1'b0;
    #1;
    push(22'd0);
    compare("abort_immediate");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      push(22'd0);
      expect_next($sformatf("abort_post_k%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
